poly1305_mac_engine: RTL and testbench
======================================

# poly1305_mac_engine

Parametrised Poly1305 one-time authenticator for the ChaCha20-Poly1305 datapath. It takes the 256-bit one-time key and a stream of 128-bit little-endian blocks, and produces the 128-bit tag. It runs in two modes:
- AEAD (RFC 8439 §2.8): separate AAD and payload sections, zero padding, and an internally generated length block.
- Raw Poly1305 (RFC 8439 §2.5): a single message with 0x01 padding.

The multiplier is digit-serial; the digit width trades area against throughput.

## Interface
- MUL_DIGIT_W, 32: bits of r consumed per multiply cycle. Legal values are 8, 16, 32, 64, 128. N = 128/MUL_DIGIT_W.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  session start pulse; sampled in IDLE or DONE only
- mode  in  1  0 = AEAD, 1 = raw; latched on start
- otk  in  256  one-time key, latched on start: r = clamp(otk[127:0]), s = otk[255:128]
- in_valid / in_ready  in/out  1  block handshake; transfer when both are high on a clock edge
- in_data  in  128  block data; byte i in bits [8i+7:8i]
- in_keep  in  16  valid byte mask; contiguous from bit 0, so 0..16 ones
- in_sel  in  1  section select: 0 = AAD, 1 = payload; ignored in raw mode
- in_last  in  1  final block of the current section
- tag  out  128  authenticator; little-endian
- tag_valid  out  1  held high in DONE
- busy  out  1  high in every state except IDLE and DONE
- err  out  1  sticky protocol error; cleared on start

## Operation
- States: IDLE, IN, MUL, RED1, RED2, LEN, FIN, DONE.
- start in IDLE/DONE:
  - acc ← 0; byte counters ← 0; err ← 0; tag_valid ← 0.
  - r ← otk[127:0] & 0x0ffffffc0ffffffc0ffffffc0fffffff.
  - Next state IN.
- Block formation, m (129 bits): data bytes at or above the keep count are zeroed.
  - AEAD: bit 128 is always set (zero-padded full block).
  - Raw, n = 16 bytes: bit 128 set.
  - Raw, n < 16: bit 8n set, bit 128 clear.
- Empty section: keep = 0 with in_last = 1 contributes no block and no bytes, and advances the section in one cycle.
- Protocol errors set err; the block is accepted but ignored:
  - keep = 0 without in_last;
  - non-contiguous keep;
  - in AEAD, in_sel = 0 after the AAD section has closed.
- AEAD sections:
  - AAD blocks first; in_last on the final AAD block closes AAD.
  - Payload blocks next; in_last closes the payload.
  - 64-bit counters aad_bytes and pld_bytes accumulate keep popcounts.
- Per accepted non-empty block:
  - IN: h ← acc + m (131 bits).
  - MUL, N cycles: p ← p + h·r_digit << (k·MUL_DIGIT_W), least-significant digit first; p is 259 bits.
  - RED1: t ← p[129:0] + 5·(p >> 130).
  - RED2: acc ← t[129:0] + 5·(t >> 130). acc is 131 bits and < 2^130 + 64.
- Closing the last section:
  - AEAD: go to LEN. The length block m = {pld_bytes, aad_bytes} | 2^128 goes through MUL/RED1/RED2, then FIN.
  - Raw: go straight to FIN.
- FIN, one cycle:
  - a ← acc mod (2^130 − 5), using at most two conditional subtracts.
  - tag ← (a + s) mod 2^128.
  - Next state DONE.
- DONE: tag and tag_valid hold until start or reset. in_ready stays 0.

## Timing
- Reset: state IDLE. tag = 0, tag_valid = 0, in_ready = 0, busy = 0, err = 0. Internal acc, r, s and counters = 0.
- in_ready is combinationally 1 only in state IN.
- Non-empty block throughput: one block per N + 3 cycles (7 cycles at MUL_DIGIT_W = 32).
- Empty-section block: IN stays ready on the next cycle.
- After the final block is accepted:
  - AEAD: tag_valid rises N + 3 + N + 3 + 1 cycles after the acceptance edge.
  - Raw: tag_valid rises N + 3 + 1 cycles after the acceptance edge.
- start while busy is ignored.
- rst_n low at any point (e.g. mid-MUL) returns to IDLE immediately with the reset values above. No partial tag is ever flagged valid.
- A tag is bit-identical for every legal MUL_DIGIT_W.

## Test plan
- Raw RFC 8439 §2.5.2:
  - Stimulus: otk = 85d6be78…4149f51b; "Cryptographic Forum Research Group" (34 bytes) sent as keep 0xFFFF, 0xFFFF, 0x0003, with last on the third block.
  - Required: tag = a8061dc1305136c6c22b8baf0c0127a9.
- AEAD RFC 8439 §2.8.2:
  - Stimulus: otk = 7bac2b252db447af…3ed553ff; 12-byte AAD; 114-byte ciphertext from the RFC.
  - Required: internal length block = 12 | 114 << 64; tag = 1ae10b594f09e26a7e902ecbd0600691.
  - Repeat with MUL_DIGIT_W = 8 and 128: same tag.
- Empty sections:
  - Stimulus: AEAD with AAD keep = 0 / last and payload keep = 0 / last; otk[127:0] = 0, s = 0x0F…0F.
  - Required: tag = s; tag_valid high, busy low.
- Throughput, MUL_DIGIT_W = 32, in_valid held high:
  - in_ready pulses exactly every 7 cycles.
  - A 3-block raw message gives tag_valid 8 cycles after the third acceptance.
- Error:
  - Stimulus: block with keep = 0x00F1.
  - Required: err = 1 and stays high; acc is unchanged (the tag equals that of the same session without the bad block); start clears err.
- Reset mid-operation: assert rst_n low during MUL of block 2. All outputs return to their reset values at once; a subsequent fresh session reproduces the §2.5.2 tag.

Source files
------------

// File: rtl/poly1305_mac_engine.sv
// Poly1305 one-time authenticator with a digit-serial multiplier.
// Supports AEAD framing with an internal length block, and raw Poly1305.
module poly1305_mac_engine #(
  parameter int MUL_DIGIT_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mode,
  input  logic [255:0] otk,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [15:0]  in_keep,
  input  logic         in_sel,
  input  logic         in_last,
  output logic [127:0] tag,
  output logic         tag_valid,
  output logic         busy,
  output logic         err
);
  localparam int N = 128 / MUL_DIGIT_W;
  localparam logic [130:0] P1305 = (131'd1 << 130) - 131'd5;
  localparam logic [127:0] CLAMP = 128'h0ffffffc0ffffffc0ffffffc0fffffff;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_IN   = 3'd1;
  localparam logic [2:0] S_MUL  = 3'd2;
  localparam logic [2:0] S_RED1 = 3'd3;
  localparam logic [2:0] S_RED2 = 3'd4;
  localparam logic [2:0] S_LEN  = 3'd5;
  localparam logic [2:0] S_FIN  = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  logic [2:0]   state;
  logic         mode_raw, aad_closed, final_blk, len_phase;
  logic [127:0] r, s, r_sh;
  logic [130:0] acc;
  logic [258:0] h_sh, p;
  logic [131:0] t;
  logic [63:0]  aad_bytes, pld_bytes;
  logic [7:0]   k;

  logic [4:0]   blk_n;
  logic [15:0]  blk_ones;
  logic         blk_bad, blk_empty, blk_close;
  logic [128:0] blk_m;
  logic [131:0] red1;
  logic [258:0] digit_ext;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'b0, v[i]};
    return c;
  endfunction

  // Raw mode puts the 0x01 pad byte right after the data; AEAD blocks are zero-padded full blocks.
  function automatic logic [128:0] form_block(input logic [127:0] d, input logic [4:0] n,
                                              input logic raw);
    logic [128:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) begin
      if (5'(i) < n) m[8*i +: 8] = d[8*i +: 8];
      if (raw && 5'(i) == n) m[8*i] = 1'b1;
    end
    if (!raw || n == 5'd16) m[128] = 1'b1;
    return m;
  endfunction

  // 2^130 == 5 (mod p): fold the high part back in.
  function automatic logic [131:0] fold_hi(input logic [258:0] x);
    return {2'b00, x[129:0]} + ({3'b000, x[258:130]} * 132'd5);
  endfunction

  function automatic logic [130:0] fold_lo(input logic [131:0] x);
    return {1'b0, x[129:0]} + ({129'b0, x[131:130]} * 131'd5);
  endfunction

  function automatic logic [127:0] finish_tag(input logic [130:0] a_in, input logic [127:0] s_in);
    logic [130:0] a;
    a = a_in;
    if (a >= P1305) a = a - P1305;
    if (a >= P1305) a = a - P1305;
    return a[127:0] + s_in;
  endfunction

  always_comb begin
    blk_n     = popcount16(in_keep);
    blk_ones  = 16'((17'd1 << blk_n) - 17'd1);
    blk_bad   = (in_keep != blk_ones) || (blk_n == 5'd0 && !in_last) ||
                (!mode_raw && !in_sel && aad_closed);
    blk_empty = (blk_n == 5'd0);
    blk_close = in_last && (mode_raw || in_sel);
    blk_m     = form_block(in_data, blk_n, mode_raw);
    digit_ext = {{(259-MUL_DIGIT_W){1'b0}}, r_sh[MUL_DIGIT_W-1:0]};
    red1      = fold_hi(p);
  end

  assign in_ready = (state == S_IN);
  assign busy     = (state != S_IDLE) && (state != S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      mode_raw   <= 1'b0;
      aad_closed <= 1'b0;
      final_blk  <= 1'b0;
      len_phase  <= 1'b0;
      r          <= '0;
      s          <= '0;
      r_sh       <= '0;
      acc        <= '0;
      h_sh       <= '0;
      p          <= '0;
      t          <= '0;
      aad_bytes  <= '0;
      pld_bytes  <= '0;
      k          <= '0;
      tag        <= '0;
      tag_valid  <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            mode_raw   <= mode;
            r          <= otk[127:0] & CLAMP;
            s          <= otk[255:128];
            acc        <= '0;
            aad_bytes  <= '0;
            pld_bytes  <= '0;
            aad_closed <= 1'b0;
            final_blk  <= 1'b0;
            len_phase  <= 1'b0;
            err        <= 1'b0;
            tag_valid  <= 1'b0;
            state      <= S_IN;
          end
        end
        S_IN: begin
          if (in_valid) begin
            if (blk_bad) begin
              err <= 1'b1;
            end else begin
              // Any payload block, or the last AAD block, closes the AAD section.
              if (!mode_raw && (in_sel || in_last)) aad_closed <= 1'b1;
              if (mode_raw || in_sel) pld_bytes <= pld_bytes + 64'(blk_n);
              else                    aad_bytes <= aad_bytes + 64'(blk_n);
              if (blk_empty) begin
                if (blk_close) state <= mode_raw ? S_FIN : S_LEN;
              end else begin
                h_sh      <= {128'b0, acc + {2'b00, blk_m}};
                r_sh      <= r;
                p         <= '0;
                k         <= '0;
                final_blk <= blk_close;
                state     <= S_MUL;
              end
            end
          end
        end
        S_MUL: begin
          p    <= p + h_sh * digit_ext;
          h_sh <= h_sh << MUL_DIGIT_W;
          r_sh <= r_sh >> MUL_DIGIT_W;
          k    <= k + 8'd1;
          if (k == 8'(N-1)) state <= S_RED1;
        end
        S_RED1: begin
          t     <= red1;
          state <= S_RED2;
        end
        S_RED2: begin
          acc <= fold_lo(t);
          if (len_phase)      state <= S_FIN;
          else if (final_blk) state <= mode_raw ? S_FIN : S_LEN;
          else                state <= S_IN;
        end
        S_LEN: begin
          h_sh      <= {128'b0, acc + {3'b001, pld_bytes, aad_bytes}};
          r_sh      <= r;
          p         <= '0;
          k         <= '0;
          len_phase <= 1'b1;
          state     <= S_MUL;
        end
        S_FIN: begin
          tag       <= finish_tag(acc, s);
          tag_valid <= 1'b1;
          state     <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_poly1305_mac_engine.sv
// Bench for poly1305_mac_engine: RFC 8439 vectors plus randomized sessions
// against an arbitrary-precision Poly1305 reference model.
module tb_poly1305_mac_engine;
  localparam logic [127:0] CLAMP = 128'h0ffffffc0ffffffc0ffffffc0fffffff;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start [3];
  logic         mode [3];
  logic [255:0] otk [3];
  logic         in_valid [3];
  logic         in_ready [3];
  logic [127:0] in_data [3];
  logic [15:0]  in_keep [3];
  logic         in_sel [3];
  logic         in_last [3];
  logic [127:0] tag [3];
  logic         tag_valid [3];
  logic         busy [3];
  logic         err [3];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int nd [3] = '{4, 16, 1};
  logic [7:0] aad_q[$];
  logic [7:0] pld_q[$];
  logic [7:0] mac_q[$];
  int acc_hist[$];

  always @(posedge clk) cyc <= cyc + 1;

  poly1305_mac_engine #(.MUL_DIGIT_W(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .mode(mode[0]), .otk(otk[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .in_keep(in_keep[0]), .in_sel(in_sel[0]), .in_last(in_last[0]),
    .tag(tag[0]), .tag_valid(tag_valid[0]), .busy(busy[0]), .err(err[0]));
  poly1305_mac_engine #(.MUL_DIGIT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .mode(mode[1]), .otk(otk[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .in_keep(in_keep[1]), .in_sel(in_sel[1]), .in_last(in_last[1]),
    .tag(tag[1]), .tag_valid(tag_valid[1]), .busy(busy[1]), .err(err[1]));
  poly1305_mac_engine #(.MUL_DIGIT_W(128)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .mode(mode[2]), .otk(otk[2]),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .in_keep(in_keep[2]), .in_sel(in_sel[2]), .in_last(in_last[2]),
    .tag(tag[2]), .tag_valid(tag_valid[2]), .busy(busy[2]), .err(err[2]));

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [127:0] bswap128(input logic [127:0] v);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = v[127-8*i -: 8];
    return o;
  endfunction

  function automatic logic [255:0] bswap256(input logic [255:0] v);
    logic [255:0] o;
    for (int i = 0; i < 32; i++) o[8*i +: 8] = v[255-8*i -: 8];
    return o;
  endfunction

  // Poly1305 as defined on a byte string: 16-byte chunks, each with a 0x01 byte appended.
  function automatic logic [127:0] model_tag(input logic [255:0] key);
    logic [263:0] pm, rr, a, blk;
    int len, nb;
    pm = (264'd1 << 130) - 264'd5;
    rr = {136'b0, key[127:0] & CLAMP};
    a = '0;
    len = mac_q.size();
    for (int off = 0; off < len; off += 16) begin
      nb = (len - off < 16) ? len - off : 16;
      blk = '0;
      for (int i = 0; i < nb; i++) blk[8*i +: 8] = mac_q[off+i];
      blk[8*nb] = 1'b1;
      a = ((a + blk) * rr) % pm;
    end
    return a[127:0] + key[255:128];
  endfunction

  // AEAD MAC input: aad || pad16 || ct || pad16 || le64(len aad) || le64(len ct).
  task automatic build_mac(input bit raw);
    logic [63:0] la, lp;
    mac_q.delete();
    if (raw) begin
      foreach (pld_q[i]) mac_q.push_back(pld_q[i]);
    end else begin
      foreach (aad_q[i]) mac_q.push_back(aad_q[i]);
      while (mac_q.size() % 16 != 0) mac_q.push_back(8'h00);
      foreach (pld_q[i]) mac_q.push_back(pld_q[i]);
      while (mac_q.size() % 16 != 0) mac_q.push_back(8'h00);
      la = 64'(aad_q.size());
      lp = 64'(pld_q.size());
      for (int i = 0; i < 8; i++) mac_q.push_back(la[8*i +: 8]);
      for (int i = 0; i < 8; i++) mac_q.push_back(lp[8*i +: 8]);
    end
  endtask

  function automatic logic [7:0] qbyte(input bit sel, input int idx);
    return sel ? pld_q[idx] : aad_q[idx];
  endfunction

  task automatic send_blk(input int d, input logic [127:0] data, input logic [15:0] keep,
                          input logic sel, input logic last, output int acc_cyc);
    int guard;
    guard = 0;
    in_valid[d] = 1'b1; in_data[d] = data; in_keep[d] = keep;
    in_sel[d] = sel; in_last[d] = last;
    while (in_ready[d] !== 1'b1 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) begin
      chk("ready_timeout", 0, 1);
      acc_cyc = -1;
    end else begin
      @(negedge clk);
      acc_cyc = cyc;
    end
    in_valid[d] = 1'b0;
  endtask

  task automatic send_section(input int d, input bit sel, input int inj);
    int len, nb, a;
    logic [127:0] data;
    len = sel ? pld_q.size() : aad_q.size();
    if (inj != 0) begin
      data = {$urandom, $urandom, $urandom, $urandom};
      if (inj == 1)      send_blk(d, data, 16'h00F1, sel, 1'b0, a);
      else if (inj == 2) send_blk(d, data, 16'h0000, sel, 1'b0, a);
      else               send_blk(d, data, 16'hFFFF, 1'b0, 1'b0, a);
      chk("err_set", err[d], 1);
    end
    if (len == 0) begin
      send_blk(d, '0, 16'h0000, sel, 1'b1, a);
    end else begin
      for (int off = 0; off < len; off += 16) begin
        nb = (len - off < 16) ? len - off : 16;
        for (int i = 0; i < 16; i++)
          data[8*i +: 8] = (i < nb) ? qbyte(sel, off + i) : 8'($urandom_range(0, 255));
        send_blk(d, data, 16'((17'd1 << nb) - 17'd1), sel, (off + 16 >= len), a);
        acc_hist.push_back(a);
      end
    end
  endtask

  task automatic run_session(input int d, input logic [255:0] key, input bit raw, input int inj,
                             output logic [127:0] got, output int lat);
    @(negedge clk);
    acc_hist.delete();
    start[d] = 1'b1; mode[d] = raw; otk[d] = key;
    @(negedge clk);
    start[d] = 1'b0;
    chk("err_clear", err[d], 0);
    chk("tv_clear", tag_valid[d], 0);
    if (raw) begin
      send_section(d, 1'b1, inj);
    end else begin
      send_section(d, 1'b0, 0);
      send_section(d, 1'b1, inj);
    end
    lat = 1;
    while (tag_valid[d] !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 200) chk("tag_timeout", 0, 1);
    got = tag[d];
    chk("busy_done", busy[d], 0);
  endtask

  task automatic load_rfc252();
    string m;
    m = "Cryptographic Forum Research Group";
    aad_q.delete(); pld_q.delete();
    for (int i = 0; i < m.len(); i++) pld_q.push_back(m[i]);
  endtask

  task automatic load_rfc282();
    logic [95:0] a;
    logic [127:0] ln [8];
    a = 96'h50515253c0c1c2c3c4c5c6c7;
    ln[0] = 128'hd31a8d34648e60db7b86afbc53ef7ec2;
    ln[1] = 128'ha4aded51296e08fea9e2b5a736ee62d6;
    ln[2] = 128'h3dbea45e8ca9671282fafb69da92728b;
    ln[3] = 128'h1a71de0a9e060b2905d6a5b67ecd3b36;
    ln[4] = 128'h92ddbd7f2d778b8c9803aee328091b58;
    ln[5] = 128'hfab324e4fad675945585808b4831d7bc;
    ln[6] = 128'h3ff4def08e4b7a9de576d26586cec64b;
    ln[7] = {16'h6116, 112'h0};
    aad_q.delete(); pld_q.delete();
    for (int i = 0; i < 12; i++) aad_q.push_back(a[95-8*i -: 8]);
    for (int j = 0; j < 114; j++) pld_q.push_back(ln[j/16][127-8*(j%16) -: 8]);
  endtask

  task automatic fill_rand(input int la, input int lp);
    aad_q.delete(); pld_q.delete();
    for (int i = 0; i < la; i++) aad_q.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < lp; i++) pld_q.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [255:0] k252, k282, kempty, key;
    logic [127:0] t252, t282, got, expt;
    int lat, a;

    k252 = bswap256(256'h85d6be7857556d337f4452fe42d506a80103808afb0db2fd4abff6af4149f51b);
    t252 = bswap128(128'ha8061dc1305136c6c22b8baf0c0127a9);
    k282 = bswap256(256'h7bac2b252db447af09b67a55a4e955840ae1d6731075d9eb2a9375783ed553ff);
    t282 = bswap128(128'h1ae10b594f09e26a7e902ecbd0600691);
    kempty = {{16{8'h0f}}, 128'h0};

    for (int d = 0; d < 3; d++) begin
      start[d] = 0; mode[d] = 0; otk[d] = '0; in_valid[d] = 0;
      in_data[d] = '0; in_keep[d] = '0; in_sel[d] = 0; in_last[d] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_tag", tag[d], 0);
      chk("rst_tag_valid", tag_valid[d], 0);
      chk("rst_in_ready", in_ready[d], 0);
      chk("rst_busy", busy[d], 0);
      chk("rst_err", err[d], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Raw RFC vector, with throughput and latency at 32-bit digits.
    load_rfc252();
    run_session(0, k252, 1'b1, 0, got, lat);
    chk("rfc252_tag", got, t252);
    chk("rfc252_blocks", acc_hist.size(), 3);
    if (acc_hist.size() == 3) begin
      chk("thru_gap1", acc_hist[1] - acc_hist[0], 7);
      chk("thru_gap2", acc_hist[2] - acc_hist[1], 7);
    end
    chk("raw_latency", lat, 8);

    // AEAD RFC vector on all three digit widths.
    load_rfc282();
    build_mac(1'b0);
    expt = model_tag(k282);
    for (int d = 0; d < 3; d++) begin
      run_session(d, k282, 1'b0, 0, got, lat);
      chk("rfc282_tag", got, t282);
      chk("rfc282_model", got, expt);
      chk("aead_latency", lat, 2 * nd[d] + 7);
    end
    chk("aad_bytes", dut0.aad_bytes, 12);
    chk("pld_bytes", dut0.pld_bytes, 114);

    // Empty AAD and empty payload.
    aad_q.delete(); pld_q.delete();
    run_session(0, kempty, 1'b0, 0, got, lat);
    chk("empty_tag", got, {16{8'h0f}});
    chk("empty_tag_valid", tag_valid[0], 1);

    // Bad keep mask: ignored, err sticky, then cleared by the next start.
    load_rfc252();
    run_session(0, k252, 1'b1, 1, got, lat);
    chk("err_tag", got, t252);
    repeat (3) @(negedge clk);
    chk("err_sticky", err[0], 1);

    for (int it = 0; it < 12; it++) begin
      int d, inj, la, lp;
      bit raw;
      d = it % 3;
      raw = 1'($urandom_range(0, 1));
      la = raw ? 0 : $urandom_range(0, 40);
      lp = $urandom_range(0, 70);
      inj = (it < 3) ? 0 : $urandom_range(0, 3);
      if (raw && inj == 3) inj = 1;
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      fill_rand(la, lp);
      build_mac(raw);
      expt = model_tag(key);
      run_session(d, key, raw, inj, got, lat);
      chk("rand_tag", got, expt);
      chk("rand_err", err[d], (inj != 0));
      if (lp > 0) chk("rand_latency", lat, raw ? nd[d] + 4 : 2 * nd[d] + 7);
    end

    // Reset while the second block is in the multiplier.
    load_rfc252();
    @(negedge clk);
    start[0] = 1'b1; mode[0] = 1'b1; otk[0] = k252;
    @(negedge clk);
    start[0] = 1'b0;
    for (int b = 0; b < 2; b++) begin
      logic [127:0] dat;
      for (int i = 0; i < 16; i++) dat[8*i +: 8] = pld_q[16*b + i];
      send_blk(0, dat, 16'hFFFF, 1'b1, 1'b0, a);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_tag", tag[0], 0);
    chk("midrst_tag_valid", tag_valid[0], 0);
    chk("midrst_in_ready", in_ready[0], 0);
    chk("midrst_busy", busy[0], 0);
    chk("midrst_err", err[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_session(0, k252, 1'b1, 0, got, lat);
    chk("postrst_tag", got, t252);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
